// File: rtl/bcd_conv.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble, one step per clock).
// Displayed outputs only change when a conversion completes, so the display never sees partial values.
module bcd_conv #(
    parameter bit SAT_EN = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        start,
    input  logic [13:0] bin_in,
    input  logic [3:0]  dp_in,
    output logic        busy,
    output logic        done,
    output logic [15:0] bcd_out,
    output logic [3:0]  dp_out,
    output logic        ovf
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [15:0] OVF_VAL = SAT_EN ? 16'h9999 : 16'hFFFF;
    localparam logic [3:0]  LAST_STEP = 4'd13;

    state_t      state_q;
    logic [13:0] bin_q, bin_d;
    logic [15:0] acc_q, acc_d, adj;
    logic [3:0]  step_q;
    logic [3:0]  dp_cap_q;
    logic        flag_q;
    logic        busy_q, done_q, ovf_q;
    logic [15:0] bcd_q;
    logic [3:0]  dp_q;

    // One double-dabble step: nibble adjust (4-bit wrap), then shift {acc, bin} left.
    always_comb begin
        adj = acc_q;
        for (int i = 0; i < 4; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
        end
        acc_d = (adj << 1) | {15'd0, bin_q[13]};
        bin_d = bin_q << 1;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q  <= IDLE;
            bin_q    <= '0;
            acc_q    <= '0;
            step_q   <= '0;
            dp_cap_q <= '0;
            flag_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            bcd_q    <= '0;
            dp_q     <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        bin_q    <= bin_in;
                        dp_cap_q <= dp_in;
                        flag_q   <= (bin_in > 14'd9999);
                        acc_q    <= '0;
                        step_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= SHIFT;
                    end else begin
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                SHIFT: begin
                    acc_q  <= acc_d;
                    bin_q  <= bin_d;
                    step_q <= step_q + 4'd1;
                    if (step_q == LAST_STEP) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        bcd_q   <= flag_q ? OVF_VAL : acc_d;
                        dp_q    <= dp_cap_q;
                        ovf_q   <= flag_q;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign dp_out  = dp_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_bcd_conv.sv
// Bench for bcd_conv: vector table, random values against a decimal-arithmetic model,
// and hand sequences for ignored restarts, back-to-back conversion and mid-conversion reset.
module tb_bcd_conv;

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        start = 1'b0;
    logic [13:0] bin_in = '0;
    logic [3:0]  dp_in = '0;
    logic        busy, done, ovf;
    logic [15:0] bcd_out;
    logic [3:0]  dp_out;
    logic        busy0, done0, ovf0;
    logic [15:0] bcd_out0;
    logic [3:0]  dp_out0;

    int total = 0;
    int bad = 0;

    always #5 sys_clk = ~sys_clk;

    bcd_conv #(.SAT_EN(1'b1)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .bin_in(bin_in), .dp_in(dp_in),
        .busy(busy), .done(done), .bcd_out(bcd_out), .dp_out(dp_out), .ovf(ovf));

    bcd_conv #(.SAT_EN(1'b0)) dut0 (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .bin_in(bin_in), .dp_in(dp_in),
        .busy(busy0), .done(done0), .bcd_out(bcd_out0), .dp_out(dp_out0), .ovf(ovf0));

    typedef struct {
        logic [13:0] bin;
        logic [3:0]  dp;
        logic [15:0] exp1;
        logic [15:0] exp0;
        logic        eovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_bcd(input int v, input bit sat);
        if (v > 9999) return sat ? 16'h9999 : 16'hFFFF;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Full conversion from IDLE; checks latency, busy length, result and single done pulse.
    task automatic run_conv(input logic [13:0] b, input logic [3:0] d,
                            input logic [15:0] e1, input logic [15:0] e0, input logic eo);
        int nb = 0;
        int lat = 0;
        @(negedge sys_clk);
        start = 1'b1; bin_in = b; dp_in = d;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            if (busy) nb++;
            @(posedge sys_clk); #1;
            if (done) lat = k;
        end
        chk("latency", lat, 14);
        chk("busy_cycles", nb, 14);
        chk("busy_at_done", {31'd0, busy}, 0);
        chk("bcd_sat1", {16'd0, bcd_out}, {16'd0, e1});
        chk("bcd_sat0", {16'd0, bcd_out0}, {16'd0, e0});
        chk("dp_out", {28'd0, dp_out}, {28'd0, d});
        chk("ovf", {31'd0, ovf}, {31'd0, eo});
        chk("ovf_sat0", {31'd0, ovf0}, {31'd0, eo});
        @(posedge sys_clk); #1;
        chk("done_one_cycle", {31'd0, done}, 0);
    endtask

    initial begin
        vec_t tbl[8];
        int ndone;
        logic [13:0] rb;
        logic [3:0]  rd;

        tbl[0] = '{14'd1234,  4'b0100, 16'h1234, 16'h1234, 1'b0};
        tbl[1] = '{14'd0,     4'h0,    16'h0000, 16'h0000, 1'b0};
        tbl[2] = '{14'd9999,  4'hF,    16'h9999, 16'h9999, 1'b0};
        tbl[3] = '{14'd10000, 4'h1,    16'h9999, 16'hFFFF, 1'b1};
        tbl[4] = '{14'd16383, 4'h8,    16'h9999, 16'hFFFF, 1'b1};
        tbl[5] = '{14'd1,     4'h2,    16'h0001, 16'h0001, 1'b0};
        tbl[6] = '{14'd5050,  4'hA,    16'h5050, 16'h5050, 1'b0};
        tbl[7] = '{14'd8090,  4'h5,    16'h8090, 16'h8090, 1'b0};

        // reset state
        #12;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_bcd", {16'd0, bcd_out}, 0);
        chk("rst_dp", {28'd0, dp_out}, 0);
        chk("rst_ovf", {31'd0, ovf}, 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_conv(tbl[i].bin, tbl[i].dp, tbl[i].exp1, tbl[i].exp0, tbl[i].eovf);

        for (int i = 0; i < 20; i++) begin
            rb = 14'($urandom_range(0, 16383));
            rd = 4'($urandom_range(0, 15));
            run_conv(rb, rd, ref_bcd(int'(rb), 1'b1), ref_bcd(int'(rb), 1'b0), rb > 14'd9999);
        end

        // start pulses during SHIFT are ignored
        @(negedge sys_clk);
        start = 1'b1; bin_in = 14'd777; dp_in = 4'h3;
        @(posedge sys_clk); #1;
        start = 1'b0;
        ndone = 0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 3 || k == 10) begin
                start = 1'b1; bin_in = 14'd1111; dp_in = 4'hC;
            end
            @(posedge sys_clk); #1;
            start = 1'b0;
            if (done) begin
                ndone++;
                chk("ign_latency", k, 14);
                chk("ign_bcd", {16'd0, bcd_out}, {16'd0, ref_bcd(777, 1'b1)});
                chk("ign_dp", {28'd0, dp_out}, 32'h3);
            end
        end
        chk("ign_ndone", ndone, 1);

        // back-to-back: start held through the DONE cycle
        @(negedge sys_clk);
        start = 1'b1; bin_in = 14'd1234; dp_in = 4'h0;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            @(posedge sys_clk); #1;
        end
        start = 1'b1; bin_in = 14'd42;
        @(posedge sys_clk); #1;
        chk("b2b_done1", {31'd0, done}, 1);
        chk("b2b_bcd1", {16'd0, bcd_out}, 32'h1234);
        @(posedge sys_clk); #1;
        start = 1'b0;
        chk("b2b_busy_back", {31'd0, busy}, 1);
        chk("b2b_done_low", {31'd0, done}, 0);
        for (int k = 1; k <= 13; k++) begin
            @(posedge sys_clk); #1;
        end
        chk("b2b_hold", {16'd0, bcd_out}, 32'h1234);
        chk("b2b_busy_hold", {31'd0, busy}, 1);
        @(posedge sys_clk); #1;
        chk("b2b_done2", {31'd0, done}, 1);
        chk("b2b_bcd2", {16'd0, bcd_out}, {16'd0, ref_bcd(42, 1'b1)});
        @(posedge sys_clk); #1;

        // asynchronous reset mid-conversion
        @(negedge sys_clk);
        start = 1'b1; bin_in = 14'd5678; dp_in = 4'h9;
        @(posedge sys_clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge sys_clk); #1;
        end
        #1 sys_rst = 1'b1;
        #1;
        chk("arst_busy", {31'd0, busy}, 0);
        chk("arst_done", {31'd0, done}, 0);
        chk("arst_bcd", {16'd0, bcd_out}, 0);
        chk("arst_dp", {28'd0, dp_out}, 0);
        chk("arst_ovf", {31'd0, ovf}, 0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge sys_clk); #1;
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 0);
        chk("arst_bcd_zero", {16'd0, bcd_out}, 0);
        run_conv(14'd4321, 4'h6, ref_bcd(4321, 1'b1), ref_bcd(4321, 1'b0), 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_conv.md
BCD_CONV -- requirements
Module: bcd_conv

Interface
REQ-001 SHALL have parameter SAT_EN, default 1: 1 = saturate out-of-range input to 16'h9999; 0 = output 16'hFFFF on out-of-range input.
REQ-002 SHALL have port sys_clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port start  input  1  conversion request, sampled on the rising edge.
REQ-005 SHALL have port bin_in  input  14  unsigned binary value; valid range 0..9999.
REQ-006 SHALL have port dp_in  input  4  decimal-point mask, one bit per digit.
REQ-007 SHALL have port busy  output  1  conversion in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a new result.
REQ-009 SHALL have port bcd_out  output  16  four packed BCD digits; [3:0] is units, [15:12] is thousands; feeds the display driver data input.
REQ-010 SHALL have port dp_out  output  4  dp_in captured at the accepted start; feeds the display driver point input.
REQ-011 SHALL have port ovf  output  1  set when the last accepted bin_in was greater than 9999.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, SHIFT and DONE.
REQ-013 SHALL accept start only in IDLE or DONE; accept edge = E0.
REQ-014 At E0, SHALL capture bin_in, dp_in and the flag (bin_in > 9999); SHALL clear the 16-bit BCD accumulator; SHALL enter SHIFT.
REQ-015 SHALL ignore start while in SHIFT; no capture, no restart.
REQ-016 SHALL perform one double-dabble step per clock in SHIFT: add 3 to every BCD nibble >= 5, then shift {bcd, bin} left by 1, with the bin MSB entering bcd[0].
REQ-017 SHALL run SHIFT for exactly 14 steps, on edges E1..E14, tracked by a 4-bit step counter.
REQ-018 At E14, SHALL enter DONE, register bcd_out, dp_out and ovf, and assert done.
REQ-019 SHALL drive done = 1 for exactly one cycle, following E14; latency is fixed: start sampled at E0 gives done at E14.
REQ-020 SHALL drive busy = 1 exactly while in SHIFT: 14 cycles, after E0 through E14; busy = 0 in IDLE and DONE.
REQ-021 SHALL go DONE -> IDLE on the next edge when start = 0, and DONE -> SHIFT (new E0) when start = 1 (back-to-back conversion).
REQ-022 If the flag is set, SHALL load bcd_out with 16'h9999 when SAT_EN = 1, or 16'hFFFF when SAT_EN = 0, and set ovf = 1; otherwise SHALL load the converted value and set ovf = 0.
REQ-023 SHALL hold bcd_out, dp_out and ovf stable between E14 edges, including throughout a subsequent SHIFT phase, so the display never shows partial results.
REQ-024 SHALL produce a result for bin_in = 0 like any other value: bcd_out = 16'h0000 after the full 14 steps, with no early exit.
REQ-025 SHALL compute nibble adds on 4 bits with no carry-out; range checking guarantees no nibble exceeds 9 after any step.

Reset
REQ-026 While sys_rst = 1, regardless of clock, SHALL force: state = IDLE, busy = 0, done = 0, bcd_out = 16'h0000, dp_out = 4'h0, ovf = 0, step counter = 0, shift register = 0.
REQ-027 Reset asserted during SHIFT SHALL abort the conversion: no done pulse, bcd_out remains 0.
REQ-028 After reset deasserts, the first accepted start SHALL begin a normal conversion.

Verification
REQ-029 Reset, then start with bin_in = 1234 and dp_in = 4'b0100 -> busy high 14 cycles; done pulse 14 cycles after E0; bcd_out = 16'h1234; dp_out = 4'b0100; ovf = 0.
REQ-030 bin_in = 0, then 9999 -> bcd_out = 16'h0000, then 16'h9999; ovf = 0 for both.
REQ-031 bin_in = 10000 and 16383 with SAT_EN = 1 -> bcd_out = 16'h9999, ovf = 1; with SAT_EN = 0 -> bcd_out = 16'hFFFF, ovf = 1.
REQ-032 Start pulsed again at cycles E0+3 and E0+10 with a different bin_in -> ignored; result matches the original input; exactly one done pulse.
REQ-033 Start held high during the done cycle with bin_in = 42 after a 1234 conversion -> bcd_out = 16'h1234 until the next E14, then 16'h0042; busy never drops for more than the one DONE cycle.
REQ-034 sys_rst asserted asynchronously at E0+7 -> all outputs 0 immediately; no done pulse; a new start after release yields the correct result.
